fp_mul_normalize_round: RTL and testbench
=========================================

Name: fp_mul_normalize_round

Overview:
- Downstream stage of the floating multiplier datapath.
- Consumes the sign, the raw adjusted exponent and the full 48-bit significand product; produces a packed IEEE-754 single-precision result.
- Normalizes the product, rounds to nearest-even, detects overflow and underflow, and applies special-value overrides.
- Two-stage pipeline with valid/ready handshakes on both sides.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored significand width; the product width is 2*(MAN_W+1).
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream operand bundle valid.
- in_ready  out  1  this block can accept a bundle this cycle.
- in_sign  in  1  product sign (XOR of operand signs).
- in_exp  in  10  two's-complement exponent, ea+eb-BIAS, before normalization.
- in_prod  in  48  product of the two 24-bit significands with hidden 1s (bit 47 or bit 46 is the leading 1).
- in_zero  in  1  either operand zero.
- in_inf  in  1  either operand infinity.
- in_nan  in  1  either operand NaN, or inf times zero.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  32  packed {sign, exponent, fraction}.
- out_overflow  out  1  result saturated to infinity by exponent overflow.
- out_underflow  out  1  result flushed to zero by exponent underflow.

Behaviour:
- Reset values: out_valid=0, out_result=0, out_overflow=0, out_underflow=0. Both pipeline stages are emptied. in_ready is 1 in the cycle after reset deasserts.
- A reset asserted mid-operation discards all in-flight bundles with no partial output.
- Handshake:
  - A transfer occurs when valid&&ready are both high on a clock edge.
  - in_ready = !s1_valid || s1_advance, where s1_advance = !s2_valid || out_ready.
  - in_ready is combinational from out_ready; no skid buffer.
  - out_valid, out_result and the flags stay stable while out_valid=1 and out_ready=0.
- Latency: 2 cycles from input acceptance to out_valid with no stall. Throughput is 1 per cycle when out_ready is held at 1.
- Stage 1 (normalize):
  - If in_prod[47]=1: mant = in_prod[47:24], guard = in_prod[23], sticky = OR(in_prod[22:0]), exp_n = in_exp+1.
  - Else: mant = in_prod[46:23], guard = in_prod[22], sticky = OR(in_prod[21:0]), exp_n = in_exp.
  - Special flags are registered alongside.
- Stage 2 (round/pack):
  - inc = guard && (sticky || mant[0]).
  - m25 = mant + inc, computed 25 bits wide.
  - If m25[24]=1: fraction = 0 and exp_f = exp_n+1; else fraction = m25[22:0] and exp_f = exp_n.
  - All exponent arithmetic is 10-bit signed.
- Output priority, highest first:
  - nan: 32'h7FC00000, both flags 0.
  - inf: {sign, 8'hFF, 0}, both flags 0.
  - zero: {sign, 31'b0}, both flags 0.
  - exp_f >= 255: {sign, 8'hFF, 0}, out_overflow=1.
  - exp_f <= 0: {sign, 31'b0}, out_underflow=1. Denormal results are flushed to zero; no gradual underflow.
  - Otherwise: {sign, exp_f[7:0], fraction}.
- Simultaneous events: when in_valid, s1 and s2 are all full and out_ready=1, all stages shift in the same cycle with no bubble.
- When in_ready=0, in_valid is ignored and the upstream must hold its bundle.

Decomposition:
- Shared fp package holds:
  - BIAS, EXP_MAX=255
  - QNAN=32'h7FC00000
  - field width constants
  - the stage-1 to stage-2 bundle struct {sign, exp_n, mant, guard, sticky, nan, inf, zero}
- One combinational sub-module, fp_round_pack, covers the stage-2 rounding, exponent adjust, special-value priority and packing. It is reusable by a future adder datapath.

Test Plan:
- 1.0*1.0: in_exp=127, in_prod=48'h400000000000 -> out_result=32'h3F800000, 2 cycles after acceptance, flags 0.
- 1.5*1.5: in_exp=127, in_prod=48'h900000000000 -> 32'h40100000 (normalize shift, exp 128).
- Round carry-out: in_exp=127, in_prod=48'h7FFFFFC00000 (guard tie, lsb 1) -> 32'h40000000. Tie-to-even hold: in_prod=48'h400000400000 -> 32'h3F800000.
- Overflow: in_exp=254, in_prod=48'h800000000000 -> 32'h7F800000 with out_overflow=1. Underflow: in_exp=-5, in_prod=48'h400000000000 -> 32'h00000000 with out_underflow=1.
- Specials: in_nan=1 with arbitrary data -> 32'h7FC00000. in_inf=1, in_sign=1 -> 32'hFF800000. in_zero=1, in_sign=1 -> 32'h80000000.
- Backpressure and reset:
  - Send 4 back-to-back bundles with out_ready=0 for 6 cycles -> exactly 2 accepted and in_ready=0; after release, all 4 emerge in order with no loss or duplication.
  - Assert reset with both stages full -> out_valid=0 next cycle and no stale result is ever emitted.

Source files
------------

// File: rtl/fp_mul_normalize_round_pkg.sv
// Shared single-precision constants and the normalize-to-round bundle used
// by the multiplier back end (and intended for reuse by an adder datapath).
package fp_mul_normalize_round_pkg;

   localparam int unsigned EXP_W   = 8;
   localparam int unsigned MAN_W   = 23;
   localparam int unsigned BIAS    = 127;
   localparam int unsigned EXP_MAX = 2 * BIAS + 1;     // 255, all-ones exponent
   localparam int unsigned SIG_W   = MAN_W + 1;        // significand with hidden 1
   localparam int unsigned PROD_W  = 2 * SIG_W;        // full product width
   localparam int unsigned SEXP_W  = EXP_W + 2;        // signed working exponent
   localparam int unsigned RES_W   = 1 + EXP_W + MAN_W;

   localparam logic [RES_W-1:0]         QNAN      = 32'h7FC0_0000;
   localparam logic signed [SEXP_W-1:0] SEXP_MAX  = SEXP_W'(EXP_MAX);
   localparam logic signed [SEXP_W-1:0] SEXP_ZERO = '0;

   // Normalized significand plus rounding bits and special-value flags.
   typedef struct packed {
      logic                     sign;
      logic signed [SEXP_W-1:0] exp_n;
      logic [SIG_W-1:0]         mant;
      logic                     guard;
      logic                     sticky;
      logic                     nan;
      logic                     inf;
      logic                     zero;
   } s1_bundle_t;

endpackage

// File: rtl/fp_round_pack.sv
// Combinational round-to-nearest-even, exponent adjust, special-value
// priority and IEEE single packing.
//   bundle_i     normalized significand, guard/sticky, exponent, specials
//   result_c     packed {sign, exponent, fraction}
//   overflow_c   result saturated to infinity by exponent overflow
//   underflow_c  result flushed to zero by exponent underflow
module fp_round_pack
   import fp_mul_normalize_round_pkg::*;
(
   input  s1_bundle_t       bundle_i,
   output logic [RES_W-1:0] result_c,
   output logic             overflow_c,
   output logic             underflow_c
);

   logic                     inc;
   logic [SIG_W:0]           m25;
   logic                     carry;
   logic [MAN_W-1:0]         fraction;
   logic signed [SEXP_W-1:0] exp_f;

   always_comb begin
      inc   = bundle_i.guard & (bundle_i.sticky | bundle_i.mant[0]);
      m25   = {1'b0, bundle_i.mant} + (SIG_W + 1)'(inc);
      carry = m25[SIG_W];
      // On carry-out m25 is exactly 2^24, so the shifted fraction is zero.
      fraction = carry ? m25[SIG_W-1:1] : m25[MAN_W-1:0];
      exp_f    = bundle_i.exp_n + SEXP_W'(carry);

      result_c    = '0;
      overflow_c  = 1'b0;
      underflow_c = 1'b0;
      if (bundle_i.nan) begin
         result_c = QNAN;
      end else if (bundle_i.inf) begin
         result_c = {bundle_i.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (bundle_i.zero) begin
         result_c = {bundle_i.sign, {(RES_W-1){1'b0}}};
      end else if (exp_f >= SEXP_MAX) begin
         result_c   = {bundle_i.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         overflow_c = 1'b1;
      end else if (exp_f <= SEXP_ZERO) begin
         // No gradual underflow: denormals flush to signed zero.
         result_c    = {bundle_i.sign, {(RES_W-1){1'b0}}};
         underflow_c = 1'b1;
      end else begin
         result_c = {bundle_i.sign, exp_f[EXP_W-1:0], fraction};
      end
   end

endmodule

// File: rtl/fp_mul_normalize_round.sv
// Multiplier back end: two-stage normalize / round-and-pack pipeline with
// valid/ready on both sides.
//   clk, reset                    clock, synchronous active-high reset
//   in_valid/in_ready             upstream handshake (in_ready combinational)
//   in_sign/in_exp/in_prod        sign, pre-normalization exponent, 48b product
//   in_zero/in_inf/in_nan         operand special-value flags
//   out_valid/out_ready           downstream handshake
//   out_result                    packed IEEE single result
//   out_overflow/out_underflow    saturation / flush indications
module fp_mul_normalize_round
   import fp_mul_normalize_round_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_sign,
   input  logic signed [SEXP_W-1:0] in_exp,
   input  logic [PROD_W-1:0]        in_prod,
   input  logic                     in_zero,
   input  logic                     in_inf,
   input  logic                     in_nan,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [RES_W-1:0]         out_result,
   output logic                     out_overflow,
   output logic                     out_underflow
);

   logic             s1_valid_q, s1_valid_d;
   s1_bundle_t       s1_q, s1_d;
   logic             s2_valid_q, s2_valid_d;
   logic [RES_W-1:0] result_q, result_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   s1_bundle_t       norm;
   logic             s1_advance;
   logic             in_fire;
   logic [RES_W-1:0] rp_result;
   logic             rp_overflow;
   logic             rp_underflow;

   // Stage 1: align the leading 1 to the hidden-bit position.
   always_comb begin
      norm      = '0;
      norm.sign = in_sign;
      norm.nan  = in_nan;
      norm.inf  = in_inf;
      norm.zero = in_zero;
      if (in_prod[PROD_W-1]) begin
         norm.mant   = in_prod[PROD_W-1 -: SIG_W];
         norm.guard  = in_prod[PROD_W-1-SIG_W];
         norm.sticky = |in_prod[PROD_W-2-SIG_W:0];
         norm.exp_n  = in_exp + SEXP_W'(1);
      end else begin
         norm.mant   = in_prod[PROD_W-2 -: SIG_W];
         norm.guard  = in_prod[PROD_W-2-SIG_W];
         norm.sticky = |in_prod[PROD_W-3-SIG_W:0];
         norm.exp_n  = in_exp;
      end
   end

   fp_round_pack u_round_pack (
      .bundle_i    (s1_q),
      .result_c    (rp_result),
      .overflow_c  (rp_overflow),
      .underflow_c (rp_underflow)
   );

   // Pipeline control: each stage moves when the stage after it frees up.
   always_comb begin
      s1_advance  = !s2_valid_q || out_ready;
      in_ready    = !s1_valid_q || s1_advance;
      in_fire     = in_valid && in_ready;

      s1_valid_d  = s1_valid_q;
      s1_d        = s1_q;
      s2_valid_d  = s2_valid_q;
      result_d    = result_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_d       = norm;
      end else if (s1_advance) begin
         s1_valid_d = 1'b0;
      end

      if (s1_advance) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            result_d    = rp_result;
            overflow_d  = rp_overflow;
            underflow_d = rp_underflow;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_q        <= '0;
         s2_valid_q  <= 1'b0;
         result_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_q        <= s1_d;
         s2_valid_q  <= s2_valid_d;
         result_q    <= result_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign out_valid     = s2_valid_q;
   assign out_result    = result_q;
   assign out_overflow  = overflow_q;
   assign out_underflow = underflow_q;

endmodule

// File: tb/tb_fp_mul_normalize_round.sv
// Self-checking bench for fp_mul_normalize_round: directed cases, specials,
// randomized stream with random backpressure, stall and mid-flight reset.
module tb_fp_mul_normalize_round;

   logic               clk;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic               in_sign;
   logic signed [9:0]  in_exp;
   logic [47:0]        in_prod;
   logic               in_zero;
   logic               in_inf;
   logic               in_nan;
   logic               out_valid;
   logic               out_ready;
   logic [31:0]        out_result;
   logic               out_overflow;
   logic               out_underflow;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        sign;
      int          e;
      logic [47:0] prod;
      logic        z;
      logic        i;
      logic        n;
   } vec_t;

   logic [33:0] got_q[$];
   logic [33:0] exp_q[$];

   fp_mul_normalize_round dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_sign       (in_sign),
      .in_exp        (in_exp),
      .in_prod       (in_prod),
      .in_zero       (in_zero),
      .in_inf        (in_inf),
      .in_nan        (in_nan),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every output transfer as {result, overflow, underflow}.
   always @(posedge clk) begin
      if (!reset && out_valid && out_ready)
         got_q.push_back({out_result, out_overflow, out_underflow});
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: value = prod * 2^(e-46); round the significand to 24 bits by
   // comparing the discarded remainder against half an ulp.
   function automatic logic [33:0] ref_model(input vec_t v);
      longint unsigned p, q, rem, half;
      int sh, ef;
      logic [31:0] r;
      logic ov, un;
      ov = 1'b0;
      un = 1'b0;
      if (v.n) r = 32'h7FC0_0000;
      else if (v.i) r = {v.sign, 8'hFF, 23'h0};
      else if (v.z) r = {v.sign, 31'h0};
      else begin
         p    = 64'(v.prod);
         sh   = v.prod[47] ? 24 : 23;
         ef   = v.e + (v.prod[47] ? 1 : 0);
         q    = p >> sh;
         rem  = p & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 64'd1;
         if (q == (64'd1 << 24)) begin
            q  = q >> 1;
            ef = ef + 1;
         end
         if (ef >= 255) begin
            r  = {v.sign, 8'hFF, 23'h0};
            ov = 1'b1;
         end else if (ef <= 0) begin
            r  = {v.sign, 31'h0};
            un = 1'b1;
         end else begin
            r = {v.sign, 8'(ef), 23'(q)};
         end
      end
      return {r, ov, un};
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      logic [63:0] r64;
      r64    = {$urandom, $urandom};
      v.sign = 1'($urandom_range(0, 1));
      v.e    = $urandom_range(0, 300) - 20;
      v.prod = r64[47:0];
      if ($urandom_range(0, 1) == 0) v.prod[47] = 1'b1;
      else begin
         v.prod[47] = 1'b0;
         v.prod[46] = 1'b1;
      end
      // Exercise exact ties and all-ones significands regularly.
      case ($urandom_range(0, 7))
         0: v.prod[23:0] = 24'h80_0000;
         1: v.prod[22:0] = 23'h40_0000;
         2: v.prod[46:23] = 24'hFF_FFFF;
         default: ;
      endcase
      v.n = ($urandom_range(0, 19) == 0);
      v.i = ($urandom_range(0, 19) == 0);
      v.z = ($urandom_range(0, 19) == 0);
      return v;
   endfunction

   task automatic drive(input vec_t v);
      in_valid = 1'b1;
      in_sign  = v.sign;
      in_exp   = 10'(v.e);
      in_prod  = v.prod;
      in_zero  = v.z;
      in_inf   = v.i;
      in_nan   = v.n;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = '0;
      in_prod   = '0;
      in_zero   = 1'b0;
      in_inf    = 1'b0;
      in_nan    = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      n_cmp++;
      if ({out_result, out_overflow, out_underflow} !== 34'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h/%b/%b want 0", out_result, out_overflow, out_underflow);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   // One bundle through an idle pipe; checks latency and the packed result.
   task automatic test_directed();
      vec_t        vs[13];
      logic [33:0] want[13];
      vs[0]  = '{1'b0, 127,  48'h4000_0000_0000, 1'b0, 1'b0, 1'b0}; want[0]  = {32'h3F80_0000, 2'b00};
      vs[1]  = '{1'b0, 127,  48'h9000_0000_0000, 1'b0, 1'b0, 1'b0}; want[1]  = {32'h4010_0000, 2'b00};
      vs[2]  = '{1'b0, 127,  48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0}; want[2]  = {32'h4000_0000, 2'b00};
      vs[3]  = '{1'b0, 127,  48'h4000_0040_0000, 1'b0, 1'b0, 1'b0}; want[3]  = {32'h3F80_0000, 2'b00};
      vs[4]  = '{1'b0, 254,  48'h8000_0000_0000, 1'b0, 1'b0, 1'b0}; want[4]  = {32'h7F80_0000, 2'b10};
      vs[5]  = '{1'b0, -5,   48'h4000_0000_0000, 1'b0, 1'b0, 1'b0}; want[5]  = {32'h0000_0000, 2'b01};
      vs[6]  = '{1'b1, 3,    48'h1234_5678_9ABC, 1'b0, 1'b1, 1'b1}; want[6]  = {32'h7FC0_0000, 2'b00};
      vs[7]  = '{1'b1, 127,  48'h4000_0000_0000, 1'b1, 1'b1, 1'b0}; want[7]  = {32'hFF80_0000, 2'b00};
      vs[8]  = '{1'b1, 127,  48'h4000_0000_0000, 1'b1, 1'b0, 1'b0}; want[8]  = {32'h8000_0000, 2'b00};
      vs[9]  = '{1'b0, 254,  48'h4000_0000_0000, 1'b0, 1'b0, 1'b0}; want[9]  = {32'h7F00_0000, 2'b00};
      vs[10] = '{1'b0, 1,    48'h4000_0000_0000, 1'b0, 1'b0, 1'b0}; want[10] = {32'h0080_0000, 2'b00};
      vs[11] = '{1'b1, 0,    48'h4000_0000_0000, 1'b0, 1'b0, 1'b0}; want[11] = {32'h8000_0000, 2'b01};
      vs[12] = '{1'b0, 127,  48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0}; want[12] = {32'h3F80_0002, 2'b00};
      out_ready = 1'b1;
      for (int k = 0; k < 13; k++) begin
         drive(vs[k]);
         #3;
         n_cmp++;
         if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL directed_%0d_in_ready: got %b want 1", k, in_ready);
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL directed_%0d_early_valid: got %b want 0", k, out_valid);
         end
         @(posedge clk);
         #1;
         n_cmp++;
         if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL directed_%0d_latency: out_valid got %b want 1", k, out_valid);
         end
         n_cmp++;
         if ({out_result, out_overflow, out_underflow} !== want[k]) begin
            n_err++;
            $display("FAIL directed_%0d_result: got %h ovf=%b udf=%b want %h ovf=%b udf=%b",
                     k, out_result, out_overflow, out_underflow, want[k][33:2], want[k][1], want[k][0]);
         end
         n_cmp++;
         if (want[k] !== ref_model(vs[k])) begin
            n_err++;
            $display("FAIL directed_%0d_model: model %h want %h", k, ref_model(vs[k]), want[k]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_random();
      vec_t v;
      logic fire;
      int   guard;
      got_q.delete();
      exp_q.delete();
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid  = 1'b0;
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
         end
         v = rand_vec();
         drive(v);
         guard = 0;
         do begin
            out_ready = ($urandom_range(0, 9) < 7);
            #3;
            fire = in_ready;
            @(posedge clk);
            #1;
            guard++;
         end while (!fire && guard < 50);
         if (!fire) begin
            n_cmp++;
            n_err++;
            $display("FAIL random_accept_timeout: bundle %0d not accepted", k);
            break;
         end
         exp_q.push_back(ref_model(v));
      end
      in_valid = 1'b0;
      guard = 0;
      while (got_q.size() < exp_q.size() && guard < 400) begin
         out_ready = ($urandom_range(0, 9) < 7);
         @(posedge clk);
         #1;
         guard++;
      end
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL random_count: got %0d results want %0d", got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         n_cmp++;
         if (got_q[k] !== exp_q[k]) begin
            n_err++;
            $display("FAIL random_%0d: got %h ovf=%b udf=%b want %h ovf=%b udf=%b",
                     k, got_q[k][33:2], got_q[k][1], got_q[k][0], exp_q[k][33:2], exp_q[k][1], exp_q[k][0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      vec_t        vs[4];
      logic [33:0] snap;
      logic        fire;
      int          idx;
      int          guard;
      got_q.delete();
      exp_q.delete();
      for (int k = 0; k < 4; k++) begin
         vs[k]   = rand_vec();
         vs[k].n = 1'b0;
         vs[k].i = 1'b0;
         vs[k].z = 1'b0;
         vs[k].e = 100 + k;
         exp_q.push_back(ref_model(vs[k]));
      end
      out_ready = 1'b0;
      idx = 0;
      snap = '0;
      for (int c = 0; c < 6; c++) begin
         drive(vs[idx]);
         #3;
         fire = in_ready;
         @(posedge clk);
         #1;
         if (fire) idx++;
         if (c == 2) snap = {out_result, out_overflow, out_underflow};
         if (c > 2) begin
            n_cmp++;
            if ({out_result, out_overflow, out_underflow} !== snap || out_valid !== 1'b1) begin
               n_err++;
               $display("FAIL stall_stable_c%0d: got %h valid=%b want %h valid=1",
                        c, {out_result, out_overflow, out_underflow}, out_valid, snap);
            end
         end
      end
      n_cmp++;
      if (idx != 2) begin
         n_err++;
         $display("FAIL stall_accepted: got %0d want 2", idx);
      end
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL stall_in_ready: got %b want 0", in_ready);
      end
      out_ready = 1'b1;
      guard = 0;
      while (idx < 4 && guard < 20) begin
         drive(vs[idx]);
         #3;
         fire = in_ready;
         @(posedge clk);
         #1;
         if (fire) idx++;
         guard++;
      end
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_cmp++;
      if (got_q.size() != 4) begin
         n_err++;
         $display("FAIL b2b_count: got %0d want 4", got_q.size());
      end
      for (int k = 0; k < 4 && k < got_q.size(); k++) begin
         n_cmp++;
         if (got_q[k] !== exp_q[k]) begin
            n_err++;
            $display("FAIL b2b_order_%0d: got %h want %h", k, got_q[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_reset_midflight();
      vec_t v;
      got_q.delete();
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         v   = rand_vec();
         v.n = 1'b1;
         drive(v);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_full: out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_out_valid: got %b want 0", out_valid);
      end
      n_cmp++;
      if ({out_result, out_overflow, out_underflow} !== 34'h0) begin
         n_err++;
         $display("FAIL midreset_outputs: got %h/%b/%b want 0", out_result, out_overflow, out_underflow);
      end
      out_ready = 1'b1;
      #3;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL midreset_in_ready: got %b want 1", in_ready);
      end
      repeat (8) @(posedge clk);
      #1;
      n_cmp++;
      if (got_q.size() != 0) begin
         n_err++;
         $display("FAIL midreset_stale: got %0d results want 0", got_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
